// File: rtl/int32_to_fp32.sv
// int32_to_fp32: multi-cycle signed/unsigned 32-bit integer to IEEE-754 single conversion
module int32_to_fp32 #(
   parameter bit RNE = 1'b1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] input_a,
   input  logic        signed_in,
   output logic [31:0] output_z,
   output logic        out_valid,
   input  logic        out_ready
);
   typedef enum logic [2:0] {IDLE, ABS, NORM, RND, OUT} state_t;
   state_t      state, state_nx;
   logic [31:0] a_r, mag, shifted;
   logic        s_r, sign, inc;
   logic [7:0]  exp_r, exp_rnd;
   logic [4:0]  lz;
   logic [23:0] mant_sum;
   assign in_ready  = state == IDLE;
   assign out_valid = state == OUT;
   // state register
   always_ff @(posedge clk or posedge rst)
      if (rst) state <= IDLE;
      else     state <= state_nx;
   // next-state: one pipeline step per cycle, handshakes only at IDLE and OUT
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    state_nx = in_valid ? ABS : IDLE;
         ABS:     state_nx = NORM;
         NORM:    state_nx = RND;
         RND:     state_nx = OUT;
         OUT:     state_nx = out_ready ? IDLE : OUT;
         default: state_nx = IDLE;
      endcase
   end
   // leading-zero count: highest set bit wins since it is visited last
   always_comb begin
      lz = '0;
      for (int i = 0; i < 32; i++) if (mag[i]) lz = 5'(31 - i);
   end
   // round step: carry out of the mantissa bumps the exponent and leaves the field zero
   always_comb begin
      inc      = RNE & shifted[7] & ((|shifted[6:0]) | shifted[8]);
      mant_sum = {1'b0, shifted[30:8]} + {23'd0, inc};
      exp_rnd  = exp_r + {7'd0, mant_sum[23]};
   end
   // datapath registers advanced by the state they belong to
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         a_r      <= '0;
         s_r      <= 1'b0;
         sign     <= 1'b0;
         mag      <= '0;
         shifted  <= '0;
         exp_r    <= '0;
         output_z <= '0;
      end else begin
         case (state)
            IDLE: if (in_valid) begin
               a_r <= input_a;
               s_r <= signed_in;
            end
            ABS: begin
               sign <= s_r & a_r[31];
               mag  <= (s_r & a_r[31]) ? -a_r : a_r;
            end
            NORM: begin
               shifted <= mag << lz;
               exp_r   <= 8'd158 - {3'd0, lz};
            end
            RND: output_z <= (shifted == '0) ? '0 : {sign, exp_rnd, mant_sum[22:0]};
            default: ;
         endcase
      end
endmodule

// File: tb/tb_int32_to_fp32.sv
// tb_int32_to_fp32: directed checks of both rounding modes, handshake, and reset abort
module tb_int32_to_fp32;
   logic        clk = 1'b0, rst = 1'b1, in_valid = 1'b0, signed_in = 1'b0, out_ready = 1'b0;
   logic [31:0] input_a = '0;
   logic        in_ready, out_valid, in_ready_t, out_valid_t;
   logic [31:0] output_z, output_z_t, held;
   int          total = 0, bad = 0, n;

   always #5 clk = ~clk;

   int32_to_fp32 #(.RNE(1'b1)) u_rne (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .input_a(input_a),
      .signed_in(signed_in), .output_z(output_z), .out_valid(out_valid), .out_ready(out_ready));
   int32_to_fp32 #(.RNE(1'b0)) u_trz (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_t), .input_a(input_a),
      .signed_in(signed_in), .output_z(output_z_t), .out_valid(out_valid_t), .out_ready(out_ready));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic conv(input string tag, input logic [31:0] a, input logic s,
                       input logic [31:0] e_rne, input logic [31:0] e_trz);
      @(negedge clk);
      chk({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
      in_valid = 1'b1; input_a = a; signed_in = s; out_ready = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      n = 0;
      while (!out_valid && n < 8) begin
         @(posedge clk); #1;
         n++;
      end
      chk({tag, "_latency"}, n, 32'd3);
      chk({tag, "_rne"}, output_z, e_rne);
      chk({tag, "_trz"}, output_z_t, e_trz);
      @(posedge clk); #1;
      chk({tag, "_drain"}, {31'd0, out_valid}, 32'd0);
   endtask

   initial begin
      #2;
      chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_z", output_z, 32'd0);
      @(negedge clk); rst = 1'b0;
      conv("one",      32'h00000001, 1'b1, 32'h3F800000, 32'h3F800000);
      conv("neg_one",  32'hFFFFFFFF, 1'b1, 32'hBF800000, 32'hBF800000);
      conv("umax",     32'hFFFFFFFF, 1'b0, 32'h4F800000, 32'h4F7FFFFF);
      conv("smin",     32'h80000000, 1'b1, 32'hCF000000, 32'hCF000000);
      conv("zero",     32'h00000000, 1'b1, 32'h00000000, 32'h00000000);
      conv("tie_even", 32'h01000001, 1'b1, 32'h4B800000, 32'h4B800000);
      conv("tie_odd",  32'h01000003, 1'b1, 32'h4B800002, 32'h4B800001);
      conv("tie_even2",32'h01000005, 1'b1, 32'h4B800002, 32'h4B800002);
      conv("smax",     32'h7FFFFFFF, 1'b1, 32'h4F000000, 32'h4EFFFFFF);
      // backpressure, with a stray operand offered while busy
      @(negedge clk);
      in_valid = 1'b1; input_a = 32'd100; signed_in = 1'b1; out_ready = 1'b0;
      @(posedge clk); #1;
      input_a = 32'h00000007;
      n = 0;
      while (!out_valid && n < 8) begin
         @(posedge clk); #1;
         n++;
      end
      chk("bp_latency", n, 32'd3);
      chk("bp_value", output_z, 32'h42C80000);
      held = output_z;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         chk("bp_valid", {31'd0, out_valid}, 32'd1);
         chk("bp_stable", output_z, held);
         chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
      end
      @(negedge clk); in_valid = 1'b0; out_ready = 1'b1;
      @(posedge clk); #1;
      chk("bp_release_valid", {31'd0, out_valid}, 32'd0);
      chk("bp_release_ready", {31'd0, in_ready}, 32'd1);
      // reset abort while in NORM
      @(negedge clk);
      in_valid = 1'b1; input_a = 32'h12345678; signed_in = 1'b0;
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(posedge clk); #2;
      rst = 1'b1; #1;
      chk("abort_valid", {31'd0, out_valid}, 32'd0);
      chk("abort_z", output_z, 32'd0);
      chk("abort_in_ready", {31'd0, in_ready}, 32'd1);
      @(posedge clk); #2;
      rst = 1'b0;
      conv("after_rst", 32'h00000002, 1'b0, 32'h40000000, 32'h40000000);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/int32_to_fp32.md
INT32_TO_FP32 -- requirements
Module: int32_to_fp32

Interface
REQ-001 SHALL have parameter RNE, default 1: 1 = round-to-nearest-even; 0 = truncate toward zero.
REQ-002 SHALL have port clk, input, 1: single clock; all state updates on rising edge.
REQ-003 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-004 SHALL have port in_valid, input, 1: input_a/signed_in valid.
REQ-005 SHALL have port in_ready, output, 1: block can accept an operand.
REQ-006 SHALL have port input_a, input, 32: integer operand.
REQ-007 SHALL have port signed_in, input, 1: 1 = two's complement, 0 = unsigned.
REQ-008 SHALL have port output_z, output, 32: IEEE-754 single-precision result, feeding adder operand input.
REQ-009 SHALL have port out_valid, output, 1: output_z valid.
REQ-010 SHALL have port out_ready, input, 1: consumer accepts output_z.

Function
REQ-011 SHALL implement FSM states IDLE, ABS, NORM, RND, OUT.
REQ-012 SHALL drive in_ready=1 only in IDLE.
REQ-013 SHALL accept an operand on the edge where in_valid&&in_ready, capture input_a and signed_in, and go IDLE->ABS.
REQ-014 ABS SHALL compute sign = signed_in&input_a[31] and 32-bit unsigned magnitude; signed 0x80000000 SHALL give magnitude 2^31; next state NORM.
REQ-015 NORM SHALL count leading zeros lz (0..31) of the magnitude, left-shift so bit31=1, and set exponent = 158-lz (8-bit); next state RND.
REQ-016 RND SHALL take mantissa=shifted[30:8], guard=shifted[7], sticky=|shifted[6:0].
REQ-017 With RNE=1, RND SHALL increment mantissa iff guard&&(sticky||mantissa[0]); with RNE=0, no increment.
REQ-018 Mantissa carry-out SHALL zero the mantissa and increment exponent (max result exponent 159, no overflow possible).
REQ-019 Zero magnitude SHALL produce output_z=0x00000000 (positive zero) with normal latency.
REQ-020 RND SHALL load output_z={sign,exponent,mantissa} and go to OUT.
REQ-021 OUT SHALL hold out_valid=1 and output_z stable until out_ready=1 is sampled, then go to IDLE with out_valid=0 on that edge.
REQ-022 Latency SHALL be exactly 3 cycles: out_valid rises on the 3rd rising edge after the accepting edge.
REQ-023 in_valid while not in IDLE SHALL be ignored (no capture, no state change).
REQ-024 out_ready outside OUT SHALL have no effect.
REQ-025 Throughput SHALL be at most one conversion per 4 cycles (IDLE re-entry required before next accept).

Reset
REQ-026 rst=1 SHALL immediately, independent of clk, force state IDLE, out_valid=0, output_z=0x00000000, and clear all internal registers.
REQ-027 in_ready SHALL read 1 during and after reset.
REQ-028 Reset asserted mid-conversion SHALL abort it; no out_valid for that operand after release.
REQ-029 An operand presented in the first cycle after reset release SHALL be accepted.

Verification
REQ-030 Bench SHALL check: input_a=0x00000001, signed_in=1 -> 0x3F800000, out_valid 3 edges after accept.
REQ-031 Bench SHALL check: input_a=0xFFFFFFFF, signed_in=1 -> 0xBF800000; signed_in=0, RNE=1 -> 0x4F800000; signed_in=0, RNE=0 -> 0x4F7FFFFF.
REQ-032 Bench SHALL check: input_a=0x80000000, signed_in=1 -> 0xCF000000; input_a=0x00000000 -> 0x00000000.
REQ-033 Bench SHALL check RNE ties: 0x01000001 -> 0x4B800000; 0x01000003 -> 0x4B800002; 0x01000005 -> 0x4B800002.
REQ-034 Bench SHALL check backpressure: out_ready held 0 for 5 cycles -> out_valid stays 1, output_z constant, in_ready stays 0; then out_ready=1 -> IDLE next edge.
REQ-035 Bench SHALL check reset abort: rst pulsed in NORM -> out_valid=0, output_z=0 immediately; next operand 0x00000002 -> 0x40000000.
